// File: rtl/sipo_frame_n_pkg.sv
// Shared constants for the serial-in/parallel-out framing stage.
package sipo_frame_n_pkg;

  // Framing FSM state encoding. HOLD is the only state in which a word is presented.
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Default frame width.
  localparam int unsigned WORD_N = 4;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted bits within the current partial frame; wraps from n-1 back to 0.
module sipo_bit_counter #(
  parameter int unsigned n  = 4,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LastVal = CW'(n - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count = count_q;
  assign last  = (count_q == LastVal);

  // Next count: clear wins, otherwise step and wrap on the final bit of a frame.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_frame_n.sv
// Serial-in/parallel-out framing stage: assembles n serial bits (LSB first) into a word and
// holds it behind a valid/ack handshake. Bits arriving while a word is held and not being
// acknowledged are dropped and flagged on a sticky overrun.
module sipo_frame_n
  import sipo_frame_n_pkg::*;
#(
  parameter int unsigned n  = WORD_N,
  parameter int unsigned CW = (n > 1) ? $clog2(n) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          serial_in,
  input  logic          shift_en,
  input  logic          word_ack,
  output logic [n-1:0]  word,
  output logic          word_valid,
  output logic [CW-1:0] bit_count,
  output logic          overrun
);

  logic          state_q, state_d;
  logic [n-1:0]  shreg_q, shreg_d;
  logic [n-1:0]  word_q, word_d;
  logic          overrun_q, overrun_d;

  logic [n-1:0]  shifted;
  logic          accept;
  logic          complete;
  logic          drop;
  logic          cnt_last;

  // A bit is taken in FILL, or in HOLD when the held word is acknowledged in the same cycle.
  assign accept   = shift_en & ~clear & ((state_q == ST_FILL) | word_ack);
  assign complete = accept & cnt_last;
  assign drop     = shift_en & ~clear & (state_q == ST_HOLD) & ~word_ack;

  // New bits enter at the MSB so the first bit of a frame ends up in bit 0.
  if (n == 1) begin : g_shift_one
    assign shifted = serial_in;
  end else begin : g_shift_many
    assign shifted = {serial_in, shreg_q[n-1:1]};
  end

  sipo_bit_counter #(
    .n  (n),
    .CW (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept),
    .clr     (clear),
    .count   (bit_count),
    .last    (cnt_last)
  );

  // Next-state for FSM, shift register, word register and overrun flag.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    word_d    = word_q;
    overrun_d = overrun_q;

    if (clear) begin
      state_d   = ST_FILL;
      shreg_d   = '0;
      word_d    = '0;
      overrun_d = 1'b0;
    end else begin
      if (accept) begin
        shreg_d = shifted;
      end
      if (complete) begin
        word_d = shifted;
      end
      if (drop) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        ST_FILL: begin
          if (complete) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // For n=1 the bit accepted alongside the ack completes the next word at once.
          if (word_ack) begin
            state_d = complete ? ST_HOLD : ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // State registers, all asynchronously reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FILL;
      shreg_q   <= '0;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  // Word goes to the downstream OR-reduction unchanged; valid is a direct decode of the state flop.
  assign word       = word_q;
  assign word_valid = (state_q == ST_HOLD);
  assign overrun    = overrun_q;

endmodule
